// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified IM&RAM arbiter.
// Store opcodes are forwarded untouched; the memory applies the byte/half lanes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] SH = 6'b101001;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 10000;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: data has priority until it has used up its run budget
// while fetch was waiting, then fetch gets one turn.
module mem_arb_pick #(
  parameter int MAX_DATA_RUN = 4,
  parameter int RUN_W        = $clog2(MAX_DATA_RUN + 1)
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [RUN_W-1:0] data_run,
  output logic             grant_if,
  output logic             grant_d
);

  logic starve;

  assign starve   = if_req && (data_run == RUN_W'(MAX_DATA_RUN));
  assign grant_d  = d_req && !starve;
  assign grant_if = if_req && !grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and 3-cycle sequencer (IDLE -> ACCESS -> RESP) in front
// of the single-port unified memory, with address-0 and range protection.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [31:0]       d_order,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_rena,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [31:0]       mem_order,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

  state_t           state;
  logic [RUN_W-1:0] data_run;
  logic             lat_d;
  logic             lat_we;
  logic             lat_oor;

  logic              grant_if;
  logic              grant_d;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic              win_ok;

  mem_arb_pick #(
    .MAX_DATA_RUN (MAX_DATA_RUN),
    .RUN_W        (RUN_W)
  ) u_pick (
    .if_req   (if_req),
    .d_req    (d_req),
    .data_run (data_run),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  assign win_addr = grant_d ? d_addr : if_addr;
  assign win_we   = grant_d && d_we;
  assign win_ok   = win_addr < ADDR_W'(DEPTH);

  // NOTE: every register here, outputs included, is updated with <= so all
  // of them see the pre-edge values of each other within one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: reset is sampled on the clock edge; it drops any in-flight
      // transaction without an ack.
      state     <= IDLE;
      data_run  <= '0;
      lat_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_oor   <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_rena  <= 1'b0;
      mem_wena  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_order <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if || grant_d) begin
            lat_d     <= grant_d;
            lat_we    <= win_we;
            lat_oor   <= !win_ok;
            mem_addr  <= win_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            mem_order <= grant_d ? d_order : '0;
            mem_rena  <= win_ok && !win_we;
            mem_wena  <= win_ok && win_we && (win_addr != '0);
            // Run only grows while fetch is actually being held off.
            if (grant_d && if_req)
              data_run <= (data_run == RUN_W'(MAX_DATA_RUN)) ? data_run
                                                             : data_run + RUN_W'(1);
            else
              data_run <= '0;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          mem_rena <= 1'b0;
          mem_wena <= 1'b0;
          if (lat_d) begin
            d_ack <= 1'b1;
            d_err <= lat_oor;
            if (!lat_we)
              d_rdata <= lat_oor ? '0 : mem_rdata;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= lat_oor ? '0 : mem_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          d_err  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
